trigger_event_buffer: RTL and testbench
=======================================

# trigger_event_buffer

Timestamping event FIFO directly downstream of the staged filter trigger handler. It consumes the handler's trigger output and tags every accepted trigger with a free-running cycle timestamp and the raw input-channel state. It buffers the records for the ESP32 readout path, which drains them with a simple pop/valid handshake. Overflow and read-mode blocking are counted, never silent.

## Interface
Parameters:
- TS_WIDTH, 32: timestamp counter width; record width is TS_WIDTH+2.
- DEPTH_LOG2, 4: FIFO depth = 2^DEPTH_LOG2 records.
- WINDOW_TICKS, 12000000: rate-window length in CLK cycles (only used with RATE_COUNTER_EN).

Ports:
- CLK  in  1  single clock for all logic.
- RESET  in  1  synchronous, active-high reset.
- TRIGGER_IN  in  1  trigger from the filter handler; level, may stay high several cycles.
- SIGNAL1  in  1  raw channel 1, sampled as tag bit [TS_WIDTH+1].
- SIGNAL2  in  1  raw channel 2, sampled as tag bit [TS_WIDTH].
- read_mode  in  1  1 = readout session; new captures are blocked.
- RD_EN  in  1  pop request.
- DATA_OUT  out  TS_WIDTH+2  popped record {SIGNAL1, SIGNAL2, timestamp}.
- DATA_VALID  out  1  one-cycle strobe qualifying DATA_OUT.
- EMPTY  out  1  FIFO holds 0 records.
- FULL  out  1  FIFO holds 2^DEPTH_LOG2 records.
- COUNT  out  DEPTH_LOG2+1  records held.
- DROPPED  out  16  saturating count of lost triggers.
- RATE_OUT  out  16  accepted triggers in the last complete window.

## Operation
- ts_ctr: free-running TS_WIDTH counter, +1 every cycle, wraps to 0 from all-ones.
- Edge detect: a trigger event is a cycle with TRIGGER_IN=1 and the previous-cycle TRIGGER_IN=0. A level held high yields exactly one event.
- On an event, the capture record is {SIGNAL1, SIGNAL2, ts_ctr} sampled in the event cycle.
- Acceptance: the event is written when read_mode=0 and (FULL=0 or a pop is accepted in the same cycle). Otherwise DROPPED increments, saturating at 0xFFFF.
- Pop is accepted when RD_EN=1 and EMPTY=0. RD_EN while EMPTY=1 is ignored and produces no DATA_VALID.
- Simultaneous write and pop: both proceed and COUNT is unchanged. This applies when full, but not when empty, where only the write occurs.
- Pointers: write and read pointers are DEPTH_LOG2 bits and wrap naturally. COUNT is tracked separately. FULL = (COUNT==2^DEPTH_LOG2) and EMPTY = (COUNT==0).
- read_mode does not affect popping. Toggling it mid-stream only gates capture, starting from the cycle it is sampled high.
- DATA_OUT holds the last popped record until the next pop.

## Timing
- Reset (RESET=1 at a CLK edge) clears ts_ctr, pointers, COUNT, DROPPED, RATE_OUT, DATA_OUT, DATA_VALID and the edge-detect history to 0, and sets EMPTY=1, FULL=0.
- After reset, TRIGGER_IN already high in the first cycle counts as an event, because history=0.
- Reset asserted mid-operation discards all stored records. A pop accepted in the reset cycle is discarded.
- Event cycle N: the record is stored at edge N+1. COUNT, EMPTY and FULL update at edge N+1.
- Pop accepted in cycle M: DATA_OUT is loaded and DATA_VALID=1 in cycle M+1 only. Back-to-back pops give back-to-back valids.
- An event in the same cycle as a pop from a 1-record FIFO is not readable until the following cycle. There is no bypass.
- Minimum event spacing is 2 cycles. The upstream holdoff makes this irrelevant in practice, but the block must handle it.

## Configuration
- RATE_COUNTER_EN defined: a window counter counts 0..WINDOW_TICKS-1. Accepted writes are counted in a 16-bit saturating counter.
  - At window end, RATE_OUT is loaded with the count and the count restarts at 0, or at 1 if a write is accepted in that same cycle.
  - Both counters reset to 0.
- RATE_COUNTER_EN undefined: no window logic is synthesized and RATE_OUT is tied to 0.

## Test plan
- Reset, then a TRIGGER_IN pulse 5 cycles wide at ts_ctr=100 with SIGNAL1=1, SIGNAL2=0 -> COUNT=1. Pop -> DATA_VALID one cycle later with DATA_OUT={1,0,100}. Exactly one record.
- 17 isolated events with DEPTH_LOG2=4, no pops -> FULL=1, COUNT=16, DROPPED=1. Sixteen pops return timestamps in order, then EMPTY=1.
- FULL with an event and RD_EN in the same cycle -> COUNT stays 16, DROPPED unchanged, DATA_VALID next cycle with the oldest record.
- read_mode=1 with 3 events -> COUNT unchanged, DROPPED+=3. Pops still drain existing records. RD_EN on empty -> no DATA_VALID.
- ts_ctr preloaded near wrap with TS_WIDTH=8: events at 254 and 1 -> records 254 then 1, in order.
- RATE_COUNTER_EN defined, WINDOW_TICKS=100, 7 accepted events in window 1 -> RATE_OUT=7 from cycle 100. RESET mid-window -> RATE_OUT=0 and COUNT=0.

Source files
------------

// File: rtl/trigger_event_buffer_if.sv
// trigger_event_buffer_if: trigger capture inputs and FIFO readout bundle.
// slave = buffer side, master = trigger source / readout side.
interface trigger_event_buffer_if #(
    parameter int TS_WIDTH   = 32,
    parameter int DEPTH_LOG2 = 4
);
    logic                    TRIGGER_IN;
    logic                    SIGNAL1;
    logic                    SIGNAL2;
    logic                    read_mode;
    logic                    RD_EN;
    logic [TS_WIDTH+1:0]     DATA_OUT;
    logic                    DATA_VALID;
    logic                    EMPTY;
    logic                    FULL;
    logic [DEPTH_LOG2:0]     COUNT;
    logic [15:0]             DROPPED;
    logic [15:0]             RATE_OUT;

    modport slave (
        input  TRIGGER_IN, SIGNAL1, SIGNAL2, read_mode, RD_EN,
        output DATA_OUT, DATA_VALID, EMPTY, FULL, COUNT,
        output DROPPED, RATE_OUT
    );

    modport master (
        output TRIGGER_IN, SIGNAL1, SIGNAL2, read_mode, RD_EN,
        input  DATA_OUT, DATA_VALID, EMPTY, FULL, COUNT,
        input  DROPPED, RATE_OUT
    );
endinterface

// File: rtl/trigger_event_buffer.sv
// trigger_event_buffer: timestamps trigger edges into a FIFO for readout.
// Optional RATE_COUNTER_EN adds a per-window accepted-trigger rate counter.
module trigger_event_buffer #(
    parameter int TS_WIDTH     = 32,
    parameter int DEPTH_LOG2   = 4,
    parameter int WINDOW_TICKS = 12000000
) (
    input  logic                 CLK,
    input  logic                 RESET,
    trigger_event_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RW    = TS_WIDTH + 2;
    localparam int CW    = DEPTH_LOG2 + 1;

    logic [TS_WIDTH-1:0]   r_ts;
    logic                  r_trig_d;
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic [RW-1:0]         r_mem [DEPTH];
    logic [RW-1:0]         r_dout;
    logic                  r_dvalid;
    logic [15:0]           r_dropped;

    logic                  w_event;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_accept;
    logic                  w_drop;
    logic [RW-1:0]         w_rec;

    assign w_event  = bus.TRIGGER_IN & ~r_trig_d;
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_pop    = bus.RD_EN & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_accept = w_event & ~bus.read_mode & (~w_full | w_pop);
    assign w_drop   = w_event & ~w_accept;
    assign w_rec    = {bus.SIGNAL1, bus.SIGNAL2, r_ts};

    // Free-running timestamp and trigger edge history.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ts     <= '0;
            r_trig_d <= 1'b0;
        end else begin
            r_ts     <= r_ts + TS_WIDTH'(1);
            r_trig_d <= bus.TRIGGER_IN;
        end
    end

    // Record storage; contents are don't-care until pointed at.
    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_mem[r_wptr] <= w_rec;
        end
    end

    // Pointers and occupancy; simultaneous write+pop leaves COUNT as is.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + DEPTH_LOG2'(1);
            end
            if (w_accept && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_accept && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Readout register: holds the last popped record, strobes valid once.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dout   <= '0;
            r_dvalid <= 1'b0;
        end else begin
            r_dvalid <= w_pop;
            if (w_pop) begin
                r_dout <= r_mem[r_rptr];
            end
        end
    end

    // Saturating count of triggers lost to overflow or read_mode.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dropped <= '0;
        end else if (w_drop && (r_dropped != 16'hFFFF)) begin
            r_dropped <= r_dropped + 16'd1;
        end
    end

`ifdef RATE_COUNTER_EN
    localparam int WIN_W = (WINDOW_TICKS > 1) ? $clog2(WINDOW_TICKS) : 1;

    logic [WIN_W-1:0] r_win;
    logic [15:0]      r_rate_cnt;
    logic [15:0]      r_rate_out;
    logic             w_win_end;

    assign w_win_end = (r_win == WIN_W'(WINDOW_TICKS - 1));

    // Window timer; a write on the closing cycle belongs to the next window.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_win      <= '0;
            r_rate_cnt <= '0;
            r_rate_out <= '0;
        end else if (w_win_end) begin
            r_win      <= '0;
            r_rate_out <= r_rate_cnt;
            r_rate_cnt <= {15'd0, w_accept};
        end else begin
            r_win <= r_win + WIN_W'(1);
            if (w_accept && (r_rate_cnt != 16'hFFFF)) begin
                r_rate_cnt <= r_rate_cnt + 16'd1;
            end
        end
    end

    assign bus.RATE_OUT = r_rate_out;
`else
    localparam int unused_window = WINDOW_TICKS;

    assign bus.RATE_OUT = 16'd0;
`endif

    assign bus.DATA_OUT   = r_dout;
    assign bus.DATA_VALID = r_dvalid;
    assign bus.EMPTY      = w_empty;
    assign bus.FULL       = w_full;
    assign bus.COUNT      = r_count;
    assign bus.DROPPED    = r_dropped;
endmodule

// File: tb/tb_trigger_event_buffer.sv
// tb_trigger_event_buffer: directed checks of capture, FIFO order,
// overflow/read_mode drops, timestamp wrap and the optional rate window.
module tb_trigger_event_buffer;
    localparam int TSW = 8;
    localparam int DL2 = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    logic [TSW-1:0] tb_ts = '0;

    int n_chk = 0;
    int n_bad = 0;

    logic [TSW+1:0] q[$];
    logic [TSW+1:0] rec;
    logic [TSW+1:0] last;

    trigger_event_buffer_if #(.TS_WIDTH(TSW), .DEPTH_LOG2(DL2)) bus ();

    trigger_event_buffer #(
        .TS_WIDTH(TSW),
        .DEPTH_LOG2(DL2),
        .WINDOW_TICKS(100)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    // Independent timestamp model.
    always @(posedge CLK) begin
        if (RESET) tb_ts <= '0;
        else       tb_ts <= tb_ts + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic rd);
        RESET = 1'b1;
        bus.RD_EN = rd;
        tick();
        RESET = 1'b0;
        bus.RD_EN = 1'b0;
    endtask

    function automatic logic [TSW+1:0] mk(input logic s1, input logic s2);
        return {s1, s2, tb_ts};
    endfunction

    task automatic pulse(input int w, input logic s1, input logic s2);
        bus.SIGNAL1 = s1;
        bus.SIGNAL2 = s2;
        bus.TRIGGER_IN = 1'b1;
        repeat (w) tick();
        bus.TRIGGER_IN = 1'b0;
        tick();
    endtask

    task automatic pop_chk(input string tag, input logic [TSW+1:0] want);
        bus.RD_EN = 1'b1;
        tick();
        bus.RD_EN = 1'b0;
        chk({tag, "_v"}, 32'(bus.DATA_VALID), 32'd1);
        chk(tag, 32'(bus.DATA_OUT), 32'(want));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.TRIGGER_IN = 1'b0;
        bus.SIGNAL1    = 1'b0;
        bus.SIGNAL2    = 1'b0;
        bus.read_mode  = 1'b0;
        bus.RD_EN      = 1'b0;
        tick();
        do_reset(1'b0);

        chk("rst_count", 32'(bus.COUNT), 32'd0);
        chk("rst_empty", 32'(bus.EMPTY), 32'd1);
        chk("rst_full", 32'(bus.FULL), 32'd0);
        chk("rst_drop", 32'(bus.DROPPED), 32'd0);
        chk("rst_valid", 32'(bus.DATA_VALID), 32'd0);
        chk("rst_dout", 32'(bus.DATA_OUT), 32'd0);
        chk("rst_rate", 32'(bus.RATE_OUT), 32'd0);

        // 5-cycle wide trigger at ts=100 -> exactly one record {1,0,100}
        while (tb_ts != 8'd100) tick();
        pulse(5, 1'b1, 1'b0);
        chk("t1_count", 32'(bus.COUNT), 32'd1);
        pop_chk("t1_pop", 10'h264);
        tick();
        chk("t1_novalid", 32'(bus.DATA_VALID), 32'd0);
        chk("t1_empty", 32'(bus.EMPTY), 32'd1);
        chk("t1_hold", 32'(bus.DATA_OUT), 32'h264);

        // 17 isolated events: 16 stored, 1 dropped
        for (int i = 0; i < 17; i++) begin
            rec = mk(i[0], i[1]);
            pulse(1, i[0], i[1]);
            if (i < 16) q.push_back(rec);
        end
        chk("t2_full", 32'(bus.FULL), 32'd1);
        chk("t2_count", 32'(bus.COUNT), 32'd16);
        chk("t2_drop", 32'(bus.DROPPED), 32'd1);

        // full + event + pop in same cycle
        rec = mk(1'b1, 1'b1);
        bus.SIGNAL1 = 1'b1;
        bus.SIGNAL2 = 1'b1;
        bus.TRIGGER_IN = 1'b1;
        bus.RD_EN = 1'b1;
        tick();
        bus.TRIGGER_IN = 1'b0;
        bus.RD_EN = 1'b0;
        chk("t3_valid", 32'(bus.DATA_VALID), 32'd1);
        chk("t3_oldest", 32'(bus.DATA_OUT), 32'(q.pop_front()));
        q.push_back(rec);
        chk("t3_count", 32'(bus.COUNT), 32'd16);
        chk("t3_drop", 32'(bus.DROPPED), 32'd1);

        for (int i = 0; i < 16; i++) begin
            pop_chk($sformatf("t3_pop%0d", i), q.pop_front());
        end
        chk("t3_empty", 32'(bus.EMPTY), 32'd1);
        chk("t3_count0", 32'(bus.COUNT), 32'd0);

        // read_mode blocks capture but not popping
        for (int i = 0; i < 2; i++) begin
            rec = mk(1'b0, 1'b1);
            pulse(1, 1'b0, 1'b1);
            q.push_back(rec);
        end
        bus.read_mode = 1'b1;
        for (int i = 0; i < 3; i++) pulse(1, 1'b1, 1'b1);
        chk("t4_count", 32'(bus.COUNT), 32'd2);
        chk("t4_drop", 32'(bus.DROPPED), 32'd4);
        last = q[1];
        pop_chk("t4_pop0", q.pop_front());
        pop_chk("t4_pop1", q.pop_front());
        bus.RD_EN = 1'b1;
        tick();
        bus.RD_EN = 1'b0;
        chk("t4_emptyrd", 32'(bus.DATA_VALID), 32'd0);
        chk("t4_hold", 32'(bus.DATA_OUT), 32'(last));
        bus.read_mode = 1'b0;
        tick();

        // timestamp wrap: records at 254 and 1 come out in order
        while (tb_ts != 8'd254) tick();
        pulse(1, 1'b0, 1'b1);
        while (tb_ts != 8'd1) tick();
        pulse(1, 1'b1, 1'b0);
        pop_chk("t5_254", 10'h1FE);
        pop_chk("t5_1", 10'h201);

        // one record + event + pop: no bypass of the new record
        rec = mk(1'b0, 1'b0);
        pulse(1, 1'b0, 1'b0);
        last = mk(1'b1, 1'b0);
        bus.SIGNAL1 = 1'b1;
        bus.SIGNAL2 = 1'b0;
        bus.TRIGGER_IN = 1'b1;
        bus.RD_EN = 1'b1;
        tick();
        bus.TRIGGER_IN = 1'b0;
        bus.RD_EN = 1'b0;
        chk("t5b_old", 32'(bus.DATA_OUT), 32'(rec));
        chk("t5b_count", 32'(bus.COUNT), 32'd1);
        pop_chk("t5b_new", last);

        // rate window and mid-window reset
        do_reset(1'b0);
        chk("t6_drop0", 32'(bus.DROPPED), 32'd0);
        for (int i = 0; i < 7; i++) pulse(1, 1'b0, 1'b0);
        chk("t6_count7", 32'(bus.COUNT), 32'd7);
        while (tb_ts != 8'd99) tick();
        chk("t6_rate99", 32'(bus.RATE_OUT), 32'd0);
        tick();
`ifdef RATE_COUNTER_EN
        chk("t6_rate100", 32'(bus.RATE_OUT), 32'd7);
`else
        chk("t6_rate100", 32'(bus.RATE_OUT), 32'd0);
`endif
        for (int i = 0; i < 3; i++) pulse(1, 1'b1, 1'b1);
        chk("t6_count10", 32'(bus.COUNT), 32'd10);
        do_reset(1'b1);
        chk("t6_rst_count", 32'(bus.COUNT), 32'd0);
        chk("t6_rst_empty", 32'(bus.EMPTY), 32'd1);
        chk("t6_rst_rate", 32'(bus.RATE_OUT), 32'd0);
        chk("t6_rst_valid", 32'(bus.DATA_VALID), 32'd0);
        tick();
        chk("t6_rst_novalid", 32'(bus.DATA_VALID), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
